// File: rtl/alu_pkg.sv
// Shared opcode, state and helper definitions for the sequential ALU.
// Opcodes keep the 4-bit ctrl encoding of the original single-cycle ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SLL   = 4'b0011;
  localparam logic [3:0] ALU_SRL   = 4'b0100;
  localparam logic [3:0] ALU_SRA   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULU  = 4'b1000;
  localparam logic [3:0] ALU_MULHU = 4'b1001;
  localparam logic [3:0] ALU_DIVU  = 4'b1010;
  localparam logic [3:0] ALU_REMU  = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_SLTU  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // MULU/MULHU/DIVU/REMU occupy 10xx
  function automatic logic is_multicycle(input logic [3:0] ctrl);
    return ctrl[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative unsigned multiplier (shift-add) and divider (restoring), one bit per cycle.
// hi/lo present the result of the step taken on the current edge; done flags the final step.
module seq_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic             op_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;

  // Divide by zero needs no special case: every trial subtract succeeds,
  // giving an all-ones quotient and shifting the dividend into the remainder.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    hi_n    = hi_q;
    lo_n    = lo_q;
    if (!op_q) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo_q[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      hi_n = diff[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_n = shifted[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      op_q   <= 1'b0;
    end else if (start) begin
      cnt_q  <= CW'(WIDTH);
      hi_q   <= '0;
      lo_q   <= a;
      opnd_q <= b;
      op_q   <= op;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  assign done = (cnt_q == CW'(1));
  assign hi   = hi_n;
  assign lo   = lo_n;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU behind valid/ready handshakes; all results registered.
// Single-cycle ops complete in one cycle, MUL/DIV iterate for WIDTH cycles.
module seq_alu
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o
);

  state_t state_q, state_d;

  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             sel_hi_q;

  logic             start_md;
  logic             load_alu;
  logic             load_md;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [SHW-1:0]   shamt;

  assign add_res = src1_i + src2_i;
  assign sub_res = src1_i - src2_i;
  assign shamt   = src2_i[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctrl_i)
      ALU_AND:  alu_res = src1_i & src2_i;
      ALU_OR:   alu_res = src1_i | src2_i;
      ALU_NOR:  alu_res = ~(src1_i | src2_i);
      ALU_SUB: begin
        alu_res = sub_res;
        alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (sub_res[WIDTH-1] != src1_i[WIDTH-1]);
      end
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src1_i < src2_i};
      ALU_SLL:  alu_res = src1_i << shamt;
      ALU_SRL:  alu_res = src1_i >> shamt;
      ALU_SRA:  alu_res = $signed(src1_i) >>> shamt;
      // ADD, 1110 and 1111; MUL/DIV codes land here too but are never latched
      default: begin
        alu_res = add_res;
        alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (add_res[WIDTH-1] != src1_i[WIDTH-1]);
      end
    endcase
  end

  seq_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .start (start_md),
    .op    (ctrl_i[1]),
    .a     (src1_i),
    .b     (src2_i),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_comb begin
    state_d  = state_q;
    start_md = 1'b0;
    load_alu = 1'b0;
    load_md  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (is_multicycle(ctrl_i)) begin
            start_md = 1'b1;
            state_d  = S_BUSY;
          end else begin
            load_alu = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_BUSY: begin
        if (md_done) begin
          load_md = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      sel_hi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_alu) begin
        result_q <= alu_res;
        ovf_q    <= alu_ovf;
      end else if (load_md) begin
        result_q <= sel_hi_q ? md_hi : md_lo;
        ovf_q    <= 1'b0;
      end
      // MULHU and REMU (ctrl[0] set) both take the high register
      if (start_md) sel_hi_q <= ctrl_i[0];
    end
  end

  assign ready_o    = (state_q == S_IDLE);
  assign valid_o    = (state_q == S_DONE);
  assign result_o   = result_q;
  assign zero_o     = (result_q == '0);
  assign overflow_o = ovf_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU. It keeps the same 4-bit ctrl encoding for the basic ops.
- Adds signed compare, shifts, overflow detection, and iterative unsigned multiply/divide.
- Sits in the EX stage behind a valid/ready handshake, so the pipeline can stall on long ops.
- All results are registered.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >= 8).
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  operand/op request valid.
- ready_o  output  1  block can accept a request.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- ctrl_i  input  4  operation select.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  result_o == 0.
- overflow_o  output  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- ctrl encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT (signed), 1101 SLTU, 1100 NOR (bitwise ~(A|B)).
  - 0011 SLL, 0100 SRL, 0101 SRA.
  - 1000 MULU low half, 1001 MULHU high half, 1010 DIVU quotient, 1011 REMU.
  - 1110/1111 behave as ADD.
- Shift amount is src2_i[SHW-1:0]; upper bits are ignored.
- SLT/SLTU produce WIDTH'd1 or 0.
- ADD/SUB wrap modulo 2^WIDTH. overflow_o = operands of like sign (ADD) or unlike sign (SUB) whose result sign differs from A.
- Divide by zero: quotient = all ones, remainder = src1_i; completes with normal latency.
- FSM states IDLE, BUSY, DONE:
  - ready_o = (state == IDLE), combinational.
  - IDLE & valid_i, single-cycle op: latch result, go to DONE. valid_o is high the next cycle (latency 1).
  - IDLE & valid_i, MUL/DIV op: latch operands, load counter = WIDTH, go to BUSY.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle; counter decrements. At counter == 1 the final step is written to result_o and the FSM goes to DONE. valid_o rises WIDTH+1 cycles after acceptance (33 for WIDTH = 32).
  - DONE: valid_o = 1; result_o, zero_o, and overflow_o are held stable until ready_i. On valid_o & ready_i, go to IDLE.
  - No new request is accepted in the same cycle as result handoff (throughput is at most 1 op per 2 cycles).
- Inputs are sampled only on the accept cycle; later changes to src*/ctrl_i have no effect.
- valid_i while not ready_o is ignored. The requester must hold it.
- zero_o is derived from registered result_o.
- Reset (any time, including mid-BUSY): state = IDLE, result_o = 0, zero_o = 1, overflow_o = 0, valid_o = 0, counter = 0. The in-flight op is discarded.

Decomposition:
- Shared package alu_pkg:
  - ctrl opcode localparams (ALU_AND ... ALU_REMU).
  - State encoding (S_IDLE, S_BUSY, S_DONE).
  - A function is_multicycle(ctrl).
- One sub-module, seq_muldiv_unit (WIDTH parameter):
  - Holds the iterative multiplier/divider registers and counter.
  - Interface: start, op, A, B in; done, hi, lo out.
  - seq_alu owns the FSM, the single-cycle ops, and the output registers.

Test Plan:
- Reset, then ADD 0x7FFFFFFF + 1, with ready_i held high → valid_o 1 cycle after accept, result 0x80000000, overflow_o 1, zero_o 0.
- SUB 5 - 5 → result 0, zero_o 1, overflow_o 0. SLT 0xFFFFFFFF, 1 → 1. SLTU with the same operands → 0. NOR 0, 0 → 0xFFFFFFFF.
- SRA 0x80000000 by src2 = 0x24 (amount 4) → 0xF8000000. SRL with the same operands → 0x08000000. SLL 1 by 31 → 0x80000000.
- MULU 0xFFFFFFFF × 2 → 0xFFFFFFFE, and MULHU → 0x00000001, each with valid_o exactly 33 cycles after accept. ready_o stays low throughout BUSY.
- DIVU 100 / 7 → 14, REMU → 2. DIVU x / 0 → 0xFFFFFFFF, REMU 9 / 0 → 9.
- Backpressure and reset:
  - Hold ready_i low for 5 cycles in DONE → result stable and valid_o held. Handoff occurs on the cycle ready_i rises.
  - Assert rst_i low mid-BUSY → all outputs return to reset values immediately. After release, a new ADD 2 + 3 → 5.
